// File: rtl/sprite_renderer.sv
// Sprite overlay renderer: box test, ROM address generation, color-keyed
// pixel output and a per-frame opaque pixel counter.
module sprite_renderer #(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter logic [15:0] TRANSPARENT = 16'hF81F,
    parameter logic [15:0] BG_COLOR    = 16'b0011100000001111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_clk,
    input  logic        pix_en,
    input  logic [9:0]  vga_x,
    input  logic [9:0]  vga_y,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    output logic [$clog2(SPRITE_W*SPRITE_H)-1:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] vga_data,
    output logic        is_sprite,
    output logic [15:0] opaque_count
);

    localparam int          WB  = $clog2(SPRITE_W);
    localparam int          HB  = $clog2(SPRITE_H);
    localparam int          AW  = $clog2(SPRITE_W*SPRITE_H);
    localparam logic [10:0] W11 = 11'(SPRITE_W);
    localparam logic [10:0] H11 = 11'(SPRITE_H);

    logic          frame_d_q;
    logic [9:0]    pos_x_q, pos_x_d;
    logic [9:0]    pos_y_q, pos_y_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          in_box_s1_q, in_box_s1_d;
    logic          in_box_s2_q;
    logic          en_s1_q, en_s2_q;
    logic [15:0]   vga_q, vga_d;
    logic          spr_q, spr_d;
    logic [15:0]   acc_q, acc_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          frame_edge;
    logic          in_box;
    logic          opaque_hit;
    logic [9:0]    dx, dy;

    assign frame_edge = frame_clk & ~frame_d_q;

    // 11-bit compares keep boxes near the right/bottom edge from wrapping
    assign in_box = ({1'b0, vga_x} >= {1'b0, pos_x_q}) &&
                    ({1'b0, vga_x} <  ({1'b0, pos_x_q} + W11)) &&
                    ({1'b0, vga_y} >= {1'b0, pos_y_q}) &&
                    ({1'b0, vga_y} <  ({1'b0, pos_y_q} + H11));

    assign dx = vga_x - pos_x_q;
    assign dy = vga_y - pos_y_q;

    assign opaque_hit = en_s2_q && in_box_s2_q &&
                        (rom_data != TRANSPARENT);

    always_comb begin
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        addr_d      = addr_q;
        in_box_s1_d = in_box_s1_q;
        vga_d       = vga_q;
        spr_d       = spr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        if (frame_edge) begin
            pos_x_d = sprite_x;
            pos_y_d = sprite_y;
        end

        if (pix_en) begin
            in_box_s1_d = in_box;
            addr_d      = in_box ? {dy[HB-1:0], dx[WB-1:0]} : '0;
        end

        if (en_s2_q) begin
            vga_d = opaque_hit ? rom_data : BG_COLOR;
            spr_d = opaque_hit;
        end

        // a hit landing on the frame edge starts the new frame's tally
        if (frame_edge) begin
            cnt_d = acc_q;
            acc_d = opaque_hit ? 16'd1 : 16'd0;
        end else if (opaque_hit && acc_q != 16'hFFFF) begin
            acc_d = acc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_d_q   <= 1'b1;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            addr_q      <= '0;
            in_box_s1_q <= 1'b0;
            in_box_s2_q <= 1'b0;
            en_s1_q     <= 1'b0;
            en_s2_q     <= 1'b0;
            vga_q       <= BG_COLOR;
            spr_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            frame_d_q   <= frame_clk;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            addr_q      <= addr_d;
            in_box_s1_q <= in_box_s1_d;
            in_box_s2_q <= in_box_s1_q;
            en_s1_q     <= pix_en;
            en_s2_q     <= en_s1_q;
            vga_q       <= vga_d;
            spr_q       <= spr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rom_addr     = addr_q;
    assign vga_data     = vga_q;
    assign is_sprite    = spr_q;
    assign opaque_count = cnt_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with a constant-data synchronous
// ROM model; expected values are hand-computed.
module tb_sprite_renderer;

    localparam logic [15:0] BG  = 16'b0011100000001111;
    localparam logic [15:0] KEY = 16'hF81F;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_clk;
    logic        pix_en;
    logic [9:0]  vga_x, vga_y;
    logic [9:0]  sprite_x, sprite_y;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] vga_data;
    logic        is_sprite;
    logic [15:0] opaque_count;
    logic [15:0] rom_val;

    int errors = 0;
    int checks = 0;

    sprite_renderer dut (
        .clk          (clk),
        .reset        (reset),
        .frame_clk    (frame_clk),
        .pix_en       (pix_en),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .vga_data     (vga_data),
        .is_sprite    (is_sprite),
        .opaque_count (opaque_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_val;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // present one pixel; returns just after the sampling edge
    task automatic px(input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        vga_x  = x;
        vga_y  = y;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic pix_out(input string tag, input logic [9:0] x,
                           input logic [9:0] y, input logic [9:0] ea,
                           input logic [15:0] ed, input logic es);
        px(x, y);
        check({tag, ".addr"}, 32'(rom_addr), 32'(ea));
        repeat (2) @(negedge clk);
        check({tag, ".data"}, 32'(vga_data), 32'(ed));
        check({tag, ".spr"}, 32'(is_sprite), 32'(es));
    endtask

    task automatic frame;
        @(negedge clk);
        frame_clk = 1'b1;
        @(negedge clk);
        frame_clk = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        frame_clk = 1'b0;
        pix_en    = 1'b0;
        vga_x     = '0;
        vga_y     = '0;
        sprite_x  = '0;
        sprite_y  = '0;
        rom_val   = 16'hFFFF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.data", 32'(vga_data), 32'(BG));
        check("rst.spr", 32'(is_sprite), 0);
        check("rst.cnt", 32'(opaque_count), 0);
        check("rst.addr", 32'(rom_addr), 0);

        sprite_x = 10'd100;
        sprite_y = 10'd50;
        frame;
        check("f1.cnt", 32'(opaque_count), 0);
        pix_out("tl", 10'd100, 10'd50, 10'd0, 16'hFFFF, 1'b1);
        pix_out("br", 10'd131, 10'd81, 10'd1023, 16'hFFFF, 1'b1);
        pix_out("right", 10'd132, 10'd50, 10'd0, BG, 1'b0);
        pix_out("left", 10'd99, 10'd50, 10'd0, BG, 1'b0);
        pix_out("above", 10'd100, 10'd49, 10'd0, BG, 1'b0);

        // back-to-back: in, out, in -> three consecutive results
        @(negedge clk);
        vga_x = 10'd100; vga_y = 10'd50; pix_en = 1'b1;
        @(negedge clk);
        vga_x = 10'd99;
        @(negedge clk);
        vga_x = 10'd101;
        @(negedge clk);
        pix_en = 1'b0;
        check("b2b.0", 32'(is_sprite), 1);
        @(negedge clk);
        check("b2b.1", 32'(is_sprite), 0);
        @(negedge clk);
        check("b2b.2", 32'(is_sprite), 1);

        rom_val = KEY;
        pix_out("key", 10'd110, 10'd60, 10'd330, BG, 1'b0);
        rom_val = 16'hFFFF;
        frame;
        check("f2.cnt", 32'(opaque_count), 4);

        sprite_x = 10'd1000;
        sprite_y = 10'd0;
        frame;
        check("f3.cnt", 32'(opaque_count), 0);
        pix_out("edge", 10'd1023, 10'd3, 10'd119, 16'hFFFF, 1'b1);
        pix_out("nowrap", 10'd5, 10'd3, 10'd0, BG, 1'b0);

        sprite_x = 10'd100;
        sprite_y = 10'd50;
        frame;
        check("f4.cnt", 32'(opaque_count), 1);
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 32; x++) begin
                @(negedge clk);
                vga_x  = 10'(100 + x);
                vga_y  = 10'(50 + y);
                pix_en = 1'b1;
                if (y == 16 && x == 0) sprite_x = 10'd400;
            end
        end
        @(negedge clk);
        pix_en = 1'b0;
        repeat (4) @(negedge clk);
        frame;
        check("full.cnt", 32'(opaque_count), 1024);
        pix_out("old", 10'd100, 10'd50, 10'd0, BG, 1'b0);
        pix_out("new", 10'd400, 10'd50, 10'd0, 16'hFFFF, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_renderer.md
SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 SHALL have parameter SPRITE_W, default 32, sprite width in pixels (power of two).
REQ-002 SHALL have parameter SPRITE_H, default 32, sprite height in pixels (power of two).
REQ-003 SHALL have parameter TRANSPARENT, default 16'hF81F, ROM color key treated as see-through.
REQ-004 SHALL have parameter BG_COLOR, default 16'b0011100000001111, background color (purple).
REQ-005 SHALL have port clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port frame_clk, input, 1, frame strobe (~VGA_VS); its rising edge marks frame start.
REQ-008 SHALL have port pix_en, input, 1, pixel strobe; vga_x/vga_y are sampled only in cycles where pix_en=1.
REQ-009 SHALL have ports vga_x and vga_y, input, 10 each, current pixel coordinate from vga_controller.
REQ-010 SHALL have ports sprite_x and sprite_y, input, 10 each, requested sprite top-left corner.
REQ-011 SHALL have port rom_addr, output, log2(SPRITE_W*SPRITE_H), registered sprite ROM address, row-major.
REQ-012 SHALL have port rom_data, input, 16, synchronous ROM output, valid one clk after rom_addr.
REQ-013 SHALL have port vga_data, output, 16, RGB565 pixel feeding vga_color_extend.
REQ-014 SHALL have port is_sprite, output, 1, high when vga_data carries an opaque sprite pixel.
REQ-015 SHALL have port opaque_count, output, 16, opaque sprite pixels drawn in the previous frame.

Function
REQ-016 SHALL detect a frame edge as frame_clk=1 while frame_clk_d=0, where frame_clk_d is frame_clk registered every clk.
REQ-017 SHALL latch sprite_x/sprite_y into shadow pos_x/pos_y only on a frame edge; changes mid-frame have no effect until the next edge.
REQ-018 SHALL compute in_box = (vga_x >= pos_x) && (vga_x < pos_x+SPRITE_W) && (vga_y >= pos_y) && (vga_y < pos_y+SPRITE_H), using 11-bit sums so there is no wrap when pos+size > 1023.
REQ-019 Stage 1: when pix_en=1, SHALL register in_box into in_box_s1 and rom_addr = (vga_y-pos_y)*SPRITE_W + (vga_x-pos_x); when in_box=0, rom_addr SHALL be registered as 0. When pix_en=0, stage 1 SHALL hold.
REQ-020 SHALL delay pix_en by one cycle (en_s1) and in_box_s1 by one cycle (in_box_s2), aligned with rom_data.
REQ-021 Stage 2: when en_s2 (pix_en delayed 2 cycles) = 1, SHALL load vga_data = rom_data and is_sprite = 1 if in_box_s2=1 and rom_data != TRANSPARENT; otherwise vga_data = BG_COLOR and is_sprite = 0. Otherwise both outputs SHALL hold.
REQ-022 Latency: a pixel sampled with pix_en=1 in cycle N SHALL appear on vga_data/is_sprite in cycle N+3; back-to-back pix_en SHALL give one output per cycle with no bubbles.
REQ-023 SHALL increment a 16-bit accumulator on every stage-2 load with is_sprite result 1, saturating at 16'hFFFF.
REQ-024 On a frame edge, SHALL copy the accumulator to opaque_count and clear the accumulator.
REQ-025 Frame edge coinciding with an opaque stage-2 load: opaque_count SHALL get the old accumulator value, and the accumulator SHALL become 1.
REQ-026 Pipeline contents in flight across a frame edge SHALL finish using the in_box result computed at sample time; they SHALL NOT be re-evaluated with the new pos.

Reset
REQ-027 On reset=1 at a clk edge: pos_x, pos_y, rom_addr, in_box_s1/s2, en_s1/s2, accumulator and opaque_count SHALL be 0; vga_data SHALL be BG_COLOR; is_sprite SHALL be 0.
REQ-028 On reset, frame_clk_d SHALL be set to 1, so that a frame_clk held high through reset does not create a frame edge.
REQ-029 Reset SHALL take priority over pix_en and the frame edge in the same cycle, and SHALL discard any pipeline contents in flight.

Verification
REQ-030 Reset, then idle with pix_en=0 -> vga_data=16'b0011100000001111, is_sprite=0, opaque_count=0.
REQ-031 Set sprite_x=100, sprite_y=50, give a frame edge, then sample (100,50) with pix_en -> rom_addr=0 in cycle N+1; with ROM returning 16'hFFFF, vga_data=16'hFFFF and is_sprite=1 in cycle N+3.
REQ-032 Same pos, sample (131,81) -> rom_addr=1023; sample (132,50) and (99,50) -> BG_COLOR and is_sprite=0.
REQ-033 ROM returns 16'hF81F inside the box -> vga_data=BG_COLOR, is_sprite=0, accumulator unchanged.
REQ-034 pos_x=1000: sample (1023,y) -> in_box=1 and rom_addr column 23; sample (5,y) -> not in_box (no wrap).
REQ-035 Full frame of a fully opaque 32x32 sprite, then a frame edge -> opaque_count=1024; change sprite_x mid-frame -> no effect on the drawn location until the next edge.
